jk_register_bank: RTL and testbench
===================================

// Module: jk_register_bank
// PURPOSE
//  - Parametrised bank of WIDTH edge-triggered JK flip-flops with per-bit J/K inputs.
//  - Adds parallel-load, synchronous up-count and shift modes on top of plain JK.
//  - Used as a general state/counter register wherever the single-bit JK flip-flop no longer suffices.
//  - Single clock domain. Rising-edge triggered, not master-slave.
// PARAMETERS
//  WIDTH    8     number of bits in the bank; legal range 2..32
//  RST_VAL  0     value loaded into q by reset (WIDTH bits)
// PORTS
//  clk    in   1      clock; all state changes on the rising edge
//  rst    in   1      reset, asynchronous, active-high
//  en     in   1      update enable; 0 = hold all bits in every mode
//  mode   in   2      operating mode: 00 JK, 01 LOAD, 10 COUNT, 11 SHIFT
//  j      in   WIDTH  per-bit J (used in JK mode only)
//  k      in   WIDTH  per-bit K (used in JK mode only)
//  d      in   WIDTH  parallel load data (used in LOAD mode only)
//  sin    in   1      serial input, shifted into bit 0 (used in SHIFT mode only)
//  q      out  WIDTH  register state
//  qbar   out  WIDTH  bitwise ~q, always
//  tc     out  1      terminal count; present only when JK_REG_TC_EN is defined
// BEHAVIOUR
//  - Reset: rst=1 forces q=RST_VAL and qbar=~RST_VAL immediately, with no clock edge.
//    - tc=0 during reset.
//    - While rst=1, en/mode/j/k/d/sin are ignored.
//    - First update is on the first rising clk edge with rst=0.
//    - rst asserted mid-operation discards the operation in progress; no partial update.
//  - en=0: q holds in all modes. en=1: next state per mode, registered on the rising edge (1-cycle latency).
//  - JK mode (00), per bit i:
//    - j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
//  - LOAD mode (01): q <= d.
//  - COUNT mode (10):
//    - q <= q+1, modulo 2^WIDTH.
//    - All-ones wraps to 0; no saturation, no sticky flag.
//  - SHIFT mode (11):
//    - q <= {q[WIDTH-2:0], sin}. Shift left, q[WIDTH-1] is discarded.
//  - Mode may change on any cycle.
//    - The new mode takes effect at the edge where it is sampled.
//    - No state carries over between modes.
//  - Unused inputs in a mode have no effect. X on an unused input must not propagate to q.
//  - qbar is purely combinational from q; there is no separate flop.
// CONFIGURATION
//  - Macro JK_REG_TC_EN defined:
//    - Adds output port tc.
//    - tc = en & (mode==COUNT) & (q=={WIDTH{1'b1}}), combinational.
//    - tc is high in the cycle whose edge wraps q to 0, for cascading banks.
//  - Macro JK_REG_TC_EN undefined:
//    - Port tc and its logic are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package jk_reg_pkg:
//    - 2-bit mode typedef with constants MODE_JK=2'b00, MODE_LOAD=2'b01, MODE_COUNT=2'b10, MODE_SHIFT=2'b11.
//    - JK next-state function: hold/clear/set/toggle.
//  - Sub-module jk_cell: one JK bit with async active-high reset, reset value and enable.
//    - Instantiated WIDTH times via generate.
//    - Top level computes per-bit effective J/K from the mode:
//      - LOAD: J=d, K=~d.
//      - COUNT: J=K=carry into the bit.
//      - SHIFT: J=src, K=~src.
// TESTING (WIDTH=8, RST_VAL=0 unless stated)
//  1. Reset async: q=8'h5A, rst pulses high between clock edges.
//     -> q=8'h00, qbar=8'hFF before the next edge.
//     -> With RST_VAL=8'hC3, q=8'hC3.
//  2. JK mode from q=8'hF0:
//     - j=8'h0F, k=8'h30 -> q=8'hCF after one edge.
//     - then j=k=8'hFF -> q=8'h30.
//  3. LOAD d=8'hFE, then COUNT for 3 edges -> q=FF, 00, 01.
//     -> With JK_REG_TC_EN, tc=1 only while q=FF.
//  4. SHIFT from q=8'h81: sin=1, then 0 -> q=8'h03, then 8'h06.
//  5. en=0 for 4 edges, with mode cycling and random j/k/d/sin -> q unchanged.
//  6. rst asserted during a COUNT run at q=8'h7F.
//     -> q=0 immediately.
//     -> Counting resumes 01, 02 after release.

Source files
------------

// File: rtl/jk_reg_pkg.sv
// Shared mode encoding and the JK next-state rule for the JK register bank.
// Latency: none; the package holds only types, constants and a pure function.
// Backpressure: none; nothing in the package has a handshake.
package jk_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK    = 2'b00;
    localparam mode_t MODE_LOAD  = 2'b01;
    localparam mode_t MODE_COUNT = 2'b10;
    localparam mode_t MODE_SHIFT = 2'b11;

    // Classic JK rule: 00 hold, 01 clear, 10 set, 11 toggle.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nq;
        case ({j, k})
            2'b00:   nq = q;
            2'b01:   nq = 1'b0;
            2'b10:   nq = 1'b1;
            2'b11:   nq = ~q;
            default: nq = q;
        endcase
        return nq;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop bit with enable, async active-high reset and a configurable reset value.
// Latency: one clk edge from j/k/en to q; reset acts immediately.
// Backpressure: none; en=0 simply holds the bit.
module jk_cell
    import jk_reg_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    // State bit: reset value while rst is high, JK update when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_register_bank.sv
// WIDTH-bit JK register bank with JK, parallel-load, up-count and shift-left modes.
// Latency: one clk edge from inputs to q; qbar and tc are combinational from state.
// Backpressure: none; en=0 holds every bit. Optional tc output enabled by JK_REG_TC_EN.
module jk_register_bank
    import jk_reg_pkg::*;
#(
    parameter int                 WIDTH   = 8,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
`ifdef JK_REG_TC_EN
    ,
    output logic             tc
`endif
);

    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] shift_src;

    // Ripple carry for counting: a bit toggles when every lower bit is one.
    always_comb begin
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & q[i-1];
        end
    end

    assign shift_src = {q[WIDTH-2:0], sin};

    // Map the mode onto per-bit J/K; only the inputs of the active mode are read,
    // so X on an unused input never reaches the cells. Unknown mode holds.
    always_comb begin
        j_eff = '0;
        k_eff = '0;
        case (mode)
            MODE_JK: begin
                j_eff = j;
                k_eff = k;
            end
            MODE_LOAD: begin
                j_eff = d;
                k_eff = ~d;
            end
            MODE_COUNT: begin
                j_eff = carry;
                k_eff = carry;
            end
            MODE_SHIFT: begin
                j_eff = shift_src;
                k_eff = ~shift_src;
            end
            default: begin
                j_eff = '0;
                k_eff = '0;
            end
        endcase
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell #(
            .RST_VAL (RST_VAL[g])
        ) u_cell (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .j   (j_eff[g]),
            .k   (k_eff[g]),
            .q   (q[g])
        );
    end

    assign qbar = ~q;

`ifdef JK_REG_TC_EN
    // Terminal count flags the edge that wraps all-ones to zero, for cascading.
    assign tc = en & (mode == MODE_COUNT) & (&q);
`endif

endmodule

// File: tb/tb_jk_register_bank.sv
module tb_jk_register_bank;
    import jk_reg_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j, k, d;
    logic       sin;
    logic [7:0] q, qbar, q2, qbar2;
`ifdef JK_REG_TC_EN
    logic       tc, tc2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(8), .RST_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d), .sin(sin),
        .q(q), .qbar(qbar)
`ifdef JK_REG_TC_EN
        , .tc(tc)
`endif
    );

    jk_register_bank #(.WIDTH(8), .RST_VAL(8'hC3)) dut_c3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k), .d(d), .sin(sin),
        .q(q2), .qbar(qbar2)
`ifdef JK_REG_TC_EN
        , .tc(tc2)
`endif
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_JK; j = '0; k = '0; d = '0; sin = 1'b0;
        #2;
        check("reset_q", q, 8'h00);
        check("reset_qbar", qbar, 8'hFF);
        check("reset_q_c3", q2, 8'hC3);
        check("reset_qbar_c3", qbar2, 8'h3C);
`ifdef JK_REG_TC_EN
        check("reset_tc", {7'd0, tc}, 8'h00);
`endif
        step();
        check("reset_hold_over_edge", q, 8'h00);
        rst = 1'b0;

        // Test 1: load 5A then async reset between edges.
        en = 1'b1; mode = MODE_LOAD; d = 8'h5A;
        step();
        check("load_5a", q, 8'h5A);
        check("load_5a_c3", q2, 8'h5A);
        #2 rst = 1'b1;
        #1;
        check("async_rst_q", q, 8'h00);
        check("async_rst_qbar", qbar, 8'hFF);
        check("async_rst_q_c3", q2, 8'hC3);
        rst = 1'b0;

        // Test 2: JK mode from F0.
        d = 8'hF0;
        step();
        check("load_f0", q, 8'hF0);
        mode = MODE_JK; j = 8'h0F; k = 8'h30;
        step();
        check("jk_set_clear", q, 8'hCF);
        j = 8'hFF; k = 8'hFF;
        step();
        check("jk_toggle", q, 8'h30);
        check("jk_toggle_qbar", qbar, 8'hCF);

        // Unused inputs carrying X must not disturb LOAD.
        mode = MODE_LOAD; d = 8'h3C; j = 'x; k = 'x; sin = 1'bx;
        step();
        check("load_x_unused", q, 8'h3C);

        // Test 3: load FE then count through the wrap.
        d = 8'hFE; j = '0; k = '0; sin = 1'b0;
        step();
        check("load_fe", q, 8'hFE);
        mode = MODE_COUNT; d = 'x;
        #1;
`ifdef JK_REG_TC_EN
        check("tc_at_fe", {7'd0, tc}, 8'h00);
`endif
        step();
        check("count_ff", q, 8'hFF);
`ifdef JK_REG_TC_EN
        check("tc_at_ff", {7'd0, tc}, 8'h01);
`endif
        step();
        check("count_wrap_00", q, 8'h00);
`ifdef JK_REG_TC_EN
        check("tc_at_00", {7'd0, tc}, 8'h00);
`endif
        step();
        check("count_01", q, 8'h01);

        // Test 4: shift from 81.
        mode = MODE_LOAD; d = 8'h81;
        step();
        check("load_81", q, 8'h81);
        mode = MODE_SHIFT; sin = 1'b1;
        step();
        check("shift_in_1", q, 8'h03);
        sin = 1'b0;
        step();
        check("shift_in_0", q, 8'h06);

        // Test 5: en=0 holds across every mode with random unused data.
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = 2'(i);
            j = 8'($urandom); k = 8'($urandom); d = 8'($urandom); sin = 1'($urandom);
            step();
            check("en0_hold", q, 8'h06);
        end

        // Test 6: reset in the middle of a count run at 7F.
        en = 1'b1; mode = MODE_LOAD; d = 8'h7F;
        step();
        check("load_7f", q, 8'h7F);
        mode = MODE_COUNT;
        #2 rst = 1'b1;
        #1;
        check("count_rst_q", q, 8'h00);
        check("count_rst_q_c3", q2, 8'hC3);
        step();
        check("count_rst_held", q, 8'h00);
        rst = 1'b0;
        step();
        check("count_resume_01", q, 8'h01);
        check("count_resume_c4", q2, 8'hC4);
        step();
        check("count_resume_02", q, 8'h02);
        check("count_resume_qbar", qbar, 8'hFD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
